// File: rtl/capture_drain_buffer_pkg.sv
// Shared definitions for the capture/drain result buffer: FSM state encoding
// and the full-buffer policy selector.
package capture_drain_buffer_pkg;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } cdb_state_e;

  // Full-buffer policy: stop and drop, or circular keep-last.
  localparam int unsigned WRAP_STOP = 0;
  localparam int unsigned WRAP_CIRC = 1;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port memory: one write port, one synchronous read port with
// read enable. The array has no reset so it maps onto block RAM.
module capture_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Read data holds while i_re is low; the drain skid relies on that.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/capture_drain_buffer.sv
// Captures a strobed result stream into on-chip RAM, then on end-of-image
// drains it over valid/ready with a last marker; re-armed from DONE.
module capture_drain_buffer
  import capture_drain_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16384,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned WRAP   = WRAP_STOP
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              in_we,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_done,
  input  logic              rearm,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              late_we,
  output logic              drain_done
);

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam bit                WRAP_EN   = (WRAP == WRAP_CIRC);

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + PTR_ONE;
  endfunction

  cdb_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_nxt, r_rd_addr, w_start_addr;
  logic [ADDR_W:0]   r_count, w_count_nxt, r_rd_left;
  logic              r_overflow, r_late_we;
  logic              r_rv, r_rlast;
  logic              r_sk_v, r_sk_last;
  logic [DATA_W-1:0] r_sk_data, w_rdata;

  logic w_cap, w_drain, w_full, w_mem_we, w_drop, w_rearm;
  logic w_fire, w_re, w_sk_load, w_ram_taken;

  assign w_cap   = (r_state == ST_CAPTURE);
  assign w_drain = (r_state == ST_DRAIN);
  assign w_rearm = (r_state == ST_DONE) && rearm;
  assign w_full  = (r_count == DEPTH_C);

  assign w_mem_we     = w_cap && in_we && (!w_full || WRAP_EN);
  assign w_drop       = w_cap && in_we && w_full;
  assign w_wr_ptr_nxt = w_mem_we ? ptr_inc(r_wr_ptr) : r_wr_ptr;
  assign w_count_nxt  = (w_mem_we && !w_full) ? r_count + CNT_ONE : r_count;
  // Once a circular buffer has filled, the next write slot holds the oldest beat.
  assign w_start_addr = (WRAP_EN && (w_count_nxt == DEPTH_C)) ? w_wr_ptr_nxt : '0;

  // Output stage: skid entry has priority over the RAM read register.
  assign out_valid  = w_drain && (r_sk_v || r_rv);
  assign out_data   = r_sk_v ? r_sk_data : w_rdata;
  assign out_last   = out_valid && (r_sk_v ? r_sk_last : r_rlast);
  assign w_fire     = out_valid && out_ready;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign late_we    = r_late_we;
  assign drain_done = (r_state == ST_DONE);

  // Read only when the beat now in the RAM register has somewhere to go.
  assign w_re        = w_drain && (r_rd_left != '0) && !(r_sk_v && r_rv && !w_fire);
  assign w_sk_load   = r_rv && ((!r_sk_v && !w_fire) || (r_sk_v && w_fire && w_re));
  assign w_ram_taken = (!r_sk_v && w_fire) || w_sk_load;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_CAPTURE: if (in_done) w_state_nxt = (w_count_nxt == '0) ? ST_DONE : ST_DRAIN;
      ST_DRAIN:   if (w_fire && out_last) w_state_nxt = ST_DONE;
      ST_DONE:    if (rearm) w_state_nxt = ST_CAPTURE;
      default:    w_state_nxt = ST_CAPTURE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state    <= ST_CAPTURE;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_late_we  <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_left  <= '0;
      r_rv       <= 1'b0;
      r_rlast    <= 1'b0;
      r_sk_v     <= 1'b0;
      r_sk_last  <= 1'b0;
      r_sk_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cap) begin
        r_wr_ptr <= w_wr_ptr_nxt;
        r_count  <= w_count_nxt;
        if (w_drop) r_overflow <= 1'b1;
        if (in_done) begin
          r_rd_addr <= w_start_addr;
          r_rd_left <= w_count_nxt;
        end
      end else if (in_we) begin
        r_late_we <= 1'b1;
      end
      // Rearm takes precedence over a late strobe in the same cycle.
      if (w_rearm) begin
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
        r_late_we  <= 1'b0;
      end
      if (w_re) begin
        r_rd_addr <= ptr_inc(r_rd_addr);
        r_rd_left <= r_rd_left - CNT_ONE;
        r_rlast   <= (r_rd_left == CNT_ONE);
      end
      r_rv <= w_drain && (w_re || (r_rv && !w_ram_taken));
      if (w_sk_load) begin
        r_sk_v    <= 1'b1;
        r_sk_data <= w_rdata;
        r_sk_last <= r_rlast;
      end else if (!w_drain || (r_sk_v && w_fire)) begin
        r_sk_v <= 1'b0;
      end
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_re    (w_re),
    .i_raddr (r_rd_addr),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_capture_drain_buffer.sv
// Scoreboard bench for capture_drain_buffer: one stop-mode and one circular
// instance, both DEPTH=16, sharing clock and reset.
module tb_capture_drain_buffer;

  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 16;
  localparam int unsigned AW  = 4;

  logic          clk;
  logic          clear_n;
  logic          we    [2];
  logic [DW-1:0] din   [2];
  logic          done  [2];
  logic          rearm [2];
  logic          rdy   [2];
  logic          vld   [2];
  logic [DW-1:0] dout  [2];
  logic          lst   [2];
  logic [AW:0]   cnt   [2];
  logic          ovf   [2];
  logic          late  [2];
  logic          ddone [2];

  int total;
  int bad;
  logic [DW-1:0] exp_q [$];

  capture_drain_buffer #(.DATA_W(DW), .DEPTH(DEP), .WRAP(0)) u_dut_stop (
    .clk(clk), .clear_n(clear_n), .in_we(we[0]), .in_data(din[0]), .in_done(done[0]),
    .rearm(rearm[0]), .out_valid(vld[0]), .out_data(dout[0]), .out_last(lst[0]),
    .out_ready(rdy[0]), .count(cnt[0]), .overflow(ovf[0]), .late_we(late[0]),
    .drain_done(ddone[0])
  );

  capture_drain_buffer #(.DATA_W(DW), .DEPTH(DEP), .WRAP(1)) u_dut_wrap (
    .clk(clk), .clear_n(clear_n), .in_we(we[1]), .in_data(din[1]), .in_done(done[1]),
    .rearm(rearm[1]), .out_valid(vld[1]), .out_data(dout[1]), .out_last(lst[1]),
    .out_ready(rdy[1]), .count(cnt[1]), .overflow(ovf[1]), .late_we(late[1]),
    .drain_done(ddone[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Drives n strobes; the model keeps the first DEP beats, or the last DEP if wrap.
  task automatic capture(input int idx, input int n, input logic [DW-1:0] base, input bit wrap);
    for (int i = 0; i < n; i++) begin
      we[idx]  = 1'b1;
      din[idx] = base + DW'(i);
      if (exp_q.size() < DEP) exp_q.push_back(din[idx]);
      else if (wrap) begin
        void'(exp_q.pop_front());
        exp_q.push_back(din[idx]);
      end
      @(posedge clk); #1;
    end
    we[idx] = 1'b0;
  endtask

  task automatic start_drain(input int idx);
    done[idx] = 1'b1;
    @(posedge clk); #1;
    done[idx] = 1'b0;
    @(negedge clk);
    total++;
    if (vld[idx] !== 1'b0) begin
      bad++;
      $display("FAIL lat_cycle1 out_valid got=%b want=0", vld[idx]);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int idx, input logic [7:0] pat, input int plen, input bit nobubble);
    bit            fin = 0;
    bit            stalled = 0;
    logic [DW-1:0] held = '0;
    logic          hl = 1'b0;
    logic [DW-1:0] exp;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      rdy[idx] = pat[cyc % plen];
      @(negedge clk);
      if (cyc == 0) begin
        total++;
        if (vld[idx] !== 1'b1) begin
          bad++;
          $display("FAIL lat_cycle2 out_valid got=%b want=1", vld[idx]);
        end
      end
      if (nobubble) begin
        total++;
        if (vld[idx] !== 1'b1) begin
          bad++;
          $display("FAIL bubble cyc=%0d out_valid got=%b want=1", cyc, vld[idx]);
        end
      end
      if (stalled) begin
        total++;
        if (vld[idx] !== 1'b1 || dout[idx] !== held || lst[idx] !== hl) begin
          bad++;
          $display("FAIL stall_hold got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   vld[idx], dout[idx], lst[idx], held, hl);
        end
      end
      if (vld[idx] === 1'b1 && rdy[idx] === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat got=%h want=none", dout[idx]);
          fin = 1;
        end else begin
          exp = exp_q.pop_front();
          if (dout[idx] !== exp) begin
            bad++;
            $display("FAIL beat_data got=%h want=%h", dout[idx], exp);
          end
          total++;
          if (lst[idx] !== (exp_q.size() == 0)) begin
            bad++;
            $display("FAIL beat_last data=%h got=%b want=%b", exp, lst[idx], exp_q.size() == 0);
          end
          if (lst[idx] === 1'b1) fin = 1;
        end
        stalled = 0;
      end else if (vld[idx] === 1'b1) begin
        stalled = 1;
        held    = dout[idx];
        hl      = lst[idx];
      end else begin
        stalled = 0;
      end
      @(posedge clk); #1;
    end
    rdy[idx] = 1'b0;
    total++;
    if (!fin || exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_end finished=%0d left=%0d want finished=1 left=0", fin, exp_q.size());
      exp_q.delete();
    end
    total++;
    if (vld[idx] !== 1'b0 || ddone[idx] !== 1'b1) begin
      bad++;
      $display("FAIL after_drain got v=%b done=%b want v=0 done=1", vld[idx], ddone[idx]);
    end
  endtask

  task automatic do_rearm(input int idx);
    rearm[idx] = 1'b1;
    @(posedge clk); #1;
    rearm[idx] = 1'b0;
    total++;
    if (cnt[idx] !== '0 || ovf[idx] !== 1'b0 || late[idx] !== 1'b0 || ddone[idx] !== 1'b0) begin
      bad++;
      $display("FAIL rearm got cnt=%0d ovf=%b late=%b done=%b want 0 0 0 0",
               cnt[idx], ovf[idx], late[idx], ddone[idx]);
    end
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      we[i] = 0; din[i] = '0; done[i] = 0; rearm[i] = 0; rdy[i] = 0;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (vld[i] !== 1'b0 || lst[i] !== 1'b0 || ovf[i] !== 1'b0 || late[i] !== 1'b0 ||
          ddone[i] !== 1'b0 || cnt[i] !== '0) begin
        bad++;
        $display("FAIL reset dut=%0d got v=%b l=%b ovf=%b late=%b done=%b cnt=%0d want all 0",
                 i, vld[i], lst[i], ovf[i], late[i], ddone[i], cnt[i]);
      end
    end
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    capture(0, 10, 8'h00, 0);
    total++;
    if (cnt[0] !== 5'd10) begin
      bad++;
      $display("FAIL basic_count got=%0d want=10", cnt[0]);
    end
    start_drain(0);
    drain(0, 8'h01, 1, 1);
    total++;
    if (cnt[0] !== 5'd10 || ovf[0] !== 1'b0 || late[0] !== 1'b0) begin
      bad++;
      $display("FAIL basic_done got cnt=%0d ovf=%b late=%b want 10 0 0", cnt[0], ovf[0], late[0]);
    end
  endtask

  task automatic test_overflow_stop();
    do_rearm(0);
    capture(0, 20, 8'h00, 0);
    total++;
    if (cnt[0] !== 5'd16 || ovf[0] !== 1'b1) begin
      bad++;
      $display("FAIL stop_full got cnt=%0d ovf=%b want 16 1", cnt[0], ovf[0]);
    end
    start_drain(0);
    drain(0, 8'h01, 1, 1);
  endtask

  task automatic test_wrap();
    capture(1, 20, 8'h00, 1);
    total++;
    if (cnt[1] !== 5'd16 || ovf[1] !== 1'b1) begin
      bad++;
      $display("FAIL wrap_full got cnt=%0d ovf=%b want 16 1", cnt[1], ovf[1]);
    end
    start_drain(1);
    drain(1, 8'h01, 1, 1);
  endtask

  task automatic test_backpressure();
    do_rearm(0);
    capture(0, 10, 8'hA0, 0);
    start_drain(0);
    drain(0, 8'b0000_1001, 5, 0);
  endtask

  task automatic test_empty_done();
    bit saw_valid = 0;
    do_rearm(0);
    done[0] = 1'b1;
    @(posedge clk); #1;
    done[0] = 1'b0;
    total++;
    if (ddone[0] !== 1'b1 || vld[0] !== 1'b0) begin
      bad++;
      $display("FAIL empty_done got done=%b v=%b want 1 0", ddone[0], vld[0]);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (vld[0] !== 1'b0) saw_valid = 1;
      @(posedge clk); #1;
    end
    total++;
    if (saw_valid) begin
      bad++;
      $display("FAIL empty_quiet out_valid rose got=1 want=0");
    end
    we[0] = 1'b1; din[0] = 8'hEE;
    @(posedge clk); #1;
    we[0] = 1'b0;
    total++;
    if (late[0] !== 1'b1 || cnt[0] !== '0) begin
      bad++;
      $display("FAIL late_we got late=%b cnt=%0d want 1 0", late[0], cnt[0]);
    end
    rearm[0] = 1'b1; we[0] = 1'b1; din[0] = 8'hEF;
    @(posedge clk); #1;
    rearm[0] = 1'b0; we[0] = 1'b0;
    total++;
    if (late[0] !== 1'b0 || ddone[0] !== 1'b0 || cnt[0] !== '0) begin
      bad++;
      $display("FAIL rearm_we got late=%b done=%b cnt=%0d want 0 0 0", late[0], ddone[0], cnt[0]);
    end
    capture(0, 3, 8'h61, 0);
    start_drain(0);
    drain(0, 8'h01, 1, 1);
  endtask

  task automatic test_reset_mid_drain();
    logic [DW-1:0] exp;
    do_rearm(0);
    capture(0, 10, 8'h30, 0);
    start_drain(0);
    rdy[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      total++;
      if (vld[0] !== 1'b1 || dout[0] !== exp) begin
        bad++;
        $display("FAIL pre_reset_beat got v=%b d=%h want v=1 d=%h", vld[0], dout[0], exp);
      end
      @(posedge clk); #1;
    end
    #2;
    clear_n = 1'b0;
    #1;
    total++;
    if (vld[0] !== 1'b0 || lst[0] !== 1'b0 || cnt[0] !== '0 || ddone[0] !== 1'b0 ||
        ovf[0] !== 1'b0 || late[0] !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got v=%b l=%b cnt=%0d done=%b ovf=%b late=%b want all 0",
               vld[0], lst[0], cnt[0], ddone[0], ovf[0], late[0]);
    end
    exp_q.delete();
    rdy[0] = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk); #1;
    capture(0, 3, 8'h50, 0);
    total++;
    if (cnt[0] !== 5'd3) begin
      bad++;
      $display("FAIL post_reset_count got=%0d want=3", cnt[0]);
    end
    start_drain(0);
    drain(0, 8'h01, 1, 1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_overflow_stop();
    test_wrap();
    test_backpressure();
    test_empty_done();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
